// File: rtl/fifo_wptr_full_sync.sv
// Write-side pointer, full/level/almost-full and overflow status for the async FIFO.
// Optional macro FIFO_OVF_STICKY_EN makes wovf sticky until wovf_clr.
module fifo_wptr_full_sync #(
    parameter int ADDR_W       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [ADDR_W:0]   rgray_async,
    input  logic              wovf_clr,
    output logic [ADDR_W-1:0] waddr,
    output logic              wen,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              wovf
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
    logic wfull_q, wfull_d;
    logic waf_q, waf_d;
    logic wovf_q, wovf_d;

    logic [PW-1:0] rq_gray;
    logic [PW-1:0] rq_bin;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_next;
    logic          ovf_ev;

    assign wen     = winc & ~wfull_q;
    assign waddr   = wbin_q[ADDR_W-1:0];
    assign rq_gray = sync_q[SYNC_STAGES-1];
    assign ovf_ev  = winc & wfull_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rgray_async};
        rq_bin = '0;
        for (int i = 0; i < PW; i++) begin
            rq_bin[i] = ^(rq_gray >> i);
        end
        wbin_d     = wbin_q + PW'(wen);
        wgray_next = wbin_d ^ (wbin_d >> 1);
        // Full when the writer is one lap ahead: top two Gray bits inverted.
        full_cmp   = {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]};
        level_next = wbin_d - rq_bin;
        wptr_d     = wgray_next;
        wfull_d    = (wgray_next == full_cmp);
        wlevel_d   = level_next;
        waf_d      = (level_next >= AF_TH);
`ifdef FIFO_OVF_STICKY_EN
        wovf_d     = ovf_ev | (wovf_q & ~wovf_clr);
`else
        wovf_d     = ovf_ev;
`endif
    end

`ifndef FIFO_OVF_STICKY_EN
    logic unused_wovf_clr;
    assign unused_wovf_clr = wovf_clr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            sync_q   <= '0;
            wfull_q  <= 1'b0;
            waf_q    <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            sync_q   <= sync_d;
            wfull_q  <= wfull_d;
            waf_q    <= waf_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = waf_q;
    assign wlevel       = wlevel_q;
    assign wovf         = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full_sync.sv
// Scoreboard bench for fifo_wptr_full_sync with ADDR_W=3, SYNC_STAGES=2, AFULL_THRESH=6.
module tb_fifo_wptr_full_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic [3:0] rgray_async;
    logic       wovf_clr;
    logic [2:0] waddr;
    logic       wen;
    logic [3:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       wovf;

    int checks = 0;
    int failures = 0;

    fifo_wptr_full_sync #(
        .ADDR_W(3), .SYNC_STAGES(2), .AFULL_THRESH(6)
    ) dut (
        .clk(clk), .rst(rst), .winc(winc),
        .rgray_async(rgray_async), .wovf_clr(wovf_clr),
        .waddr(waddr), .wen(wen), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
    );

    always #5 clk = ~clk;

    // mask bits: 0 wen, 1 waddr, 2 wptr, 3 wfull, 4 walmost_full, 5 wlevel, 6 wovf
    typedef struct {
        logic [6:0] m;
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wptr;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs at negedge; pre-edge fields checked just before the posedge,
    // registered fields just after it.
    task automatic cyc(input logic r, input logic w, input logic [3:0] rg,
                       input logic clr, input logic [6:0] m,
                       input logic e_wen, input logic [2:0] e_waddr,
                       input logic [3:0] e_wptr, input logic e_full,
                       input logic e_af, input logic [3:0] e_lvl,
                       input logic e_ovf);
        exp_t e;
        @(negedge clk);
        rst = r; winc = w; rgray_async = rg; wovf_clr = clr;
        e.m = m; e.wen = e_wen; e.waddr = e_waddr; e.wptr = e_wptr;
        e.full = e_full; e.af = e_af; e.lvl = e_lvl; e.ovf = e_ovf;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.m[0]) chk("wen", 32'(wen), 32'(e.wen));
                if (e.m[1]) chk("waddr", 32'(waddr), 32'(e.waddr));
                @(posedge clk);
                #1;
                if (e.m[2]) chk("wptr", 32'(wptr), 32'(e.wptr));
                if (e.m[3]) chk("wfull", 32'(wfull), 32'(e.full));
                if (e.m[4]) chk("walmost_full", 32'(walmost_full), 32'(e.af));
                if (e.m[5]) chk("wlevel", 32'(wlevel), 32'(e.lvl));
                if (e.m[6]) chk("wovf", 32'(wovf), 32'(e.ovf));
            end
        end
    end

    localparam logic [6:0] POST = 7'b1111100;
    localparam logic [6:0] ALL  = 7'b1111111;

    logic sticky;

    initial begin : stim
        int k;
        rst = 1'b1; winc = 1'b1; rgray_async = 4'b0000; wovf_clr = 1'b0;
`ifdef FIFO_OVF_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        // reset with winc high
        cyc(1, 1, 4'b0000, 0, POST, 0, 0, 4'b0000, 0, 0, 0, 0);
        cyc(1, 1, 4'b0000, 0, POST | 7'b0000010, 0, 0, 4'b0000, 0, 0, 0, 0);

        // fill 8 entries
        for (k = 1; k <= 8; k++) begin
            cyc(0, 1, 4'b0000, 0, ALL, 1, 3'(k - 1), gtab[k],
                k == 8, k >= 6, 4'(k), 0);
        end

        // overflow attempts while full
        cyc(0, 1, 4'b0000, 0, ALL, 0, 0, 4'b1100, 1, 1, 8, 1);
        cyc(0, 1, 4'b0000, 0, ALL, 0, 0, 4'b1100, 1, 1, 8, 1);
        cyc(0, 0, 4'b0000, 0, ALL, 0, 0, 4'b1100, 1, 1, 8, sticky);
        cyc(0, 0, 4'b0000, 1, ALL, 0, 0, 4'b1100, 1, 1, 8, 0);

        // read release: bin 3 visible only after two sync stages
        cyc(0, 0, 4'b0010, 0, ALL, 0, 0, 4'b1100, 1, 1, 8, 0);
        cyc(0, 0, 4'b0010, 0, ALL, 0, 0, 4'b1100, 1, 1, 8, 0);
        cyc(0, 0, 4'b0010, 0, ALL, 0, 0, 4'b1100, 0, 0, 5, 0);

        // clean restart, then reader trails writer (synced view lags 3 writes)
        cyc(1, 0, 4'b0000, 0, POST, 0, 0, 4'b0000, 0, 0, 0, 0);
        for (k = 1; k <= 25; k++) begin
            cyc(0, 1, gtab[(k - 1) % 16], 0, ALL, 1, 3'((k - 1) % 8),
                gtab[k % 16], 0, 0, 4'((k < 3) ? k : 3), 0);
        end

        // reset mid-operation with winc high and a non-zero read pointer
        cyc(1, 1, gtab[9], 0, POST | 7'b0000010, 0, 3'd1, 4'b0000, 0, 0, 0, 0);
        cyc(0, 1, 4'b0000, 0, ALL, 1, 0, 4'b0001, 0, 0, 1, 0);
        cyc(0, 1, 4'b0000, 0, ALL, 1, 1, 4'b0011, 0, 0, 2, 0);
        cyc(0, 1, 4'b0000, 0, ALL, 1, 2, 4'b0010, 0, 0, 3, 0);

        @(negedge clk);
        winc = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full_sync.md
Name: fifo_wptr_full_sync

Overview:
- Write-domain pointer and status manager for the async FIFO; successor to the fixed-width write/full block.
- Adds:
  - an internal N-stage synchronizer for the read-domain Gray pointer
  - registered full detection
  - write-side fill level and programmable almost-full
  - overflow detection
- Drives the dual-port RAM write address and the Gray write pointer exported to the read domain.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, flop stages on rgray_async (legal 2..4).
- AFULL_THRESH, 2**ADDR_W-2, walmost_full asserts when level >= this value (legal 1..2**ADDR_W).

Ports:
- clk  in  1  write-domain clock.
- rst  in  1  synchronous active-high reset.
- winc  in  1  write request.
- rgray_async  in  ADDR_W+1  Gray read pointer from read domain (asynchronous).
- wovf_clr  in  1  clears sticky overflow (used only with FIFO_OVF_STICKY_EN).
- waddr  out  ADDR_W  RAM write address.
- wen  out  1  RAM write enable.
- wptr  out  ADDR_W+1  Gray write pointer to read-domain synchronizer.
- wfull  out  1  FIFO full.
- walmost_full  out  1  level >= AFULL_THRESH.
- wlevel  out  ADDR_W+1  write-side fill level, 0..2**ADDR_W.
- wovf  out  1  write attempted while full.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge): wbin, wptr, all sync flops, wfull, walmost_full, wlevel and wovf go to 0. Reset overrides winc in the same cycle. Reset mid-operation discards the in-flight state.
- Write enable:
  - wen = winc & ~wfull (combinational); waddr = wbin[ADDR_W-1:0].
  - RAM writes mem[waddr] on the same edge.
- Pointer update:
  - wbin_next = wbin + wen, modulo 2**(ADDR_W+1); natural wrap, no saturation.
  - wptr is registered: wptr <= wbin_next ^ (wbin_next >> 1).
- Synchronizer:
  - rgray_async passes through SYNC_STAGES flops; the final stage output is rq_gray.
  - Latency from a stable rgray_async to rq_gray is SYNC_STAGES edges.
  - rq_bin = Gray-to-binary of rq_gray (combinational).
- Full detection (registered):
  - wfull <= (gray(wbin_next) == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}).
  - Asserts on the same edge as the write that fills the FIFO.
  - Deasserts SYNC_STAGES+1 edges after the read pointer change appears on rgray_async.
- Level (registered):
  - wlevel <= wbin_next - rq_bin (ADDR_W+1-bit unsigned subtraction).
  - wlevel is pessimistic: it never under-reports occupancy.
  - wlevel == 2**ADDR_W exactly when wfull==1.
- Almost-full: walmost_full <= (wbin_next - rq_bin) >= AFULL_THRESH; updates on the same edge as wlevel.
- Overflow: ovf_ev = winc & wfull.
  - Pointer, waddr and RAM are untouched on ovf_ev.
  - Default: wovf <= ovf_ev, a one-cycle pulse per rejected write.
- Simultaneous write and read-pointer advance while full: the write is rejected (wfull is the current registered value). The pointer advance frees space only after synchronization.
- No state machine beyond the pointer/sync registers. RAM array is outside this block.

Optional Feature:
- Macro: FIFO_OVF_STICKY_EN.
- Defined:
  - wovf is sticky: set by ovf_ev.
  - Cleared by rst or by wovf_clr=1 at an edge.
  - If ovf_ev and wovf_clr occur together, set wins.
- Undefined:
  - wovf is the one-cycle pulse described above.
  - wovf_clr is ignored; the port remains present.

Test Plan:
- Parameters for all scenarios: ADDR_W=3, SYNC_STAGES=2, AFULL_THRESH=6.
- Reset: rst=1 for 2 edges, winc=1 -> waddr=0, wptr=4'b0000, wfull=0, wlevel=0, wovf=0, wen blocked from advancing pointer.
- Fill: rgray_async=0, 8 consecutive winc -> after 6th edge walmost_full=1, wlevel=6. After 8th edge wfull=1, wlevel=8, wptr=4'b1100, waddr=0.
- Overflow: while full, winc=1 for 2 cycles -> wen=0, waddr/wptr unchanged.
  - Default build: wovf=1 for each cycle.
  - Sticky build: wovf stays 1 until wovf_clr pulse.
- Read release: while full, rgray_async changes 0000->0010 (bin 3) -> wfull, walmost_full and wlevel unchanged for 2 edges. On the 3rd edge: wfull=0, wlevel=5, walmost_full=0.
- Wrap: reader tracks writer (rgray_async=wptr delayed 3 cycles), 20 writes -> wptr follows Gray sequence through 1000->0000 at 16th write, waddr wraps 7->0, wfull never asserts, wlevel <= 3.
- Reset mid-operation: 5 writes then rst=1 one edge with winc=1 -> next cycle wptr=0, wlevel=0, sync flops 0; writes resume from waddr=0.
